// File: rtl/apu_audio_pkg.sv
// Shared definitions for the APU audio output controller: register
// offsets, CSR bit positions, LFSR constants and small helper functions.
package apu_audio_pkg;

   // Register byte offsets inside the 4 kB slot (only bits [3:2] decode)
   localparam logic [3:0] OFF_CSR  = 4'h0;
   localparam logic [3:0] OFF_RATE = 4'h4;
   localparam logic [3:0] OFF_FIFO = 4'h8;
   localparam logic [3:0] OFF_STAT = 4'hC;

   // CSR bit positions
   localparam int CSR_EN        = 0;
   localparam int CSR_FLUSH     = 1;
   localparam int CSR_IRQ_EN    = 2;
   localparam int CSR_UNDERFLOW = 8;
   localparam int CSR_OVERFLOW  = 9;

   // STAT field positions
   localparam int STAT_LEVEL_LSB  = 0;
   localparam int STAT_THRESH_LSB = 8;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 expressed for a right shift
   // (feedback from bits 0,2,3,5 enters at bit 15)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   // Word index of a byte offset
   function automatic logic [1:0] reg_idx(input logic [3:0] off);
      return off[3:2];
   endfunction

   // One LFSR step
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

   // Signed sample plus unsigned dither, saturating at the positive rail.
   // The dither is never negative, so the negative rail cannot be crossed.
   function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [15:0] d);
      logic signed [16:0] sum;
      sum = $signed({s[15], s}) + $signed({1'b0, d});
      if (sum > 17'sh07FFF) begin
         return 16'h7FFF;
      end
      return sum[15:0];
   endfunction

endpackage

// File: rtl/apu_audio_out_fifo.sv
// Flop-based synchronous sample FIFO (32-bit x DEPTH) with flush.
// A push while full is accepted only if a pop happens in the same cycle;
// flush wins over both push and pop.
module apu_sample_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty,
   output logic [5:0]   o_level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [5:0]    r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_level == 6'(DEPTH));
   assign o_empty   = (r_level == 6'd0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty && !i_flush;
   assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

   // Storage: the head is read before the edge, so a full push+pop may
   // overwrite the slot being popped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 6'd1;
            2'b01:   r_level <= r_level - 6'd1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/apu_audio_out.sv
// APU audio output controller: AHB-Lite register slave, stereo sample
// FIFO, sample-rate scheduler and two glitch-free PWM modulators.
// Optional build macro: APU_AUDIO_OUT_DITHER_EN adds LFSR dither ahead of
// the PWM truncation.
module apu_audio_out
   import apu_audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int W_PWM      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ahbls_haddr,
   input  logic [1:0]  ahbls_htrans,
   input  logic        ahbls_hwrite,
   input  logic [2:0]  ahbls_hsize,
   input  logic        ahbls_hready,
   output logic        ahbls_hready_resp,
   output logic        ahbls_hresp,
   input  logic [31:0] ahbls_hwdata,
   output logic [31:0] ahbls_hrdata,
   output logic        irq,
   output logic        audio_l,
   output logic        audio_r
);

   // Bus data-phase state
   logic             r_dph_valid;
   logic             r_dph_write;
   logic [1:0]       r_dph_idx;

   // Control/status registers
   logic             r_en;
   logic             r_irq_en;
   logic             r_underflow;
   logic             r_overflow;
   logic [7:0]       r_rate;
   logic [5:0]       r_thresh;

   // Playback state
   logic [W_PWM-1:0] r_ctr;
   logic [7:0]       r_period;
   logic [31:0]      r_current;
   logic             r_audio_l;
   logic             r_audio_r;
   logic             r_irq;

   logic             w_wr;
   logic             w_wr_csr;
   logic             w_wr_rate;
   logic             w_wr_fifo;
   logic             w_wr_stat;
   logic             w_flush;
   logic             w_wrap;
   logic             w_sched_pop;
   logic             w_pop_ok;
   logic             w_underflow_set;
   logic             w_overflow_set;
   logic [31:0]      w_fifo_rdata;
   logic             w_full;
   logic             w_empty;
   logic [5:0]       w_level;
   logic [15:0]      w_dither;
   logic [15:0]      w_samp_l;
   logic [15:0]      w_samp_r;
   logic [15:0]      w_off_l;
   logic [15:0]      w_off_r;
   logic [W_PWM-1:0] w_duty_l;
   logic [W_PWM-1:0] w_duty_r;
   logic             w_unused;

   assign ahbls_hready_resp = 1'b1;
   assign ahbls_hresp       = 1'b0;
   assign irq               = r_irq;
   assign audio_l           = r_audio_l;
   assign audio_r           = r_audio_r;

   // Size, upper address bits and the sequential/non-sequential distinction
   // carry no meaning for this slave
   assign w_unused = ^{ahbls_hsize, ahbls_haddr[15:4], ahbls_haddr[1:0], ahbls_htrans[0]};

   // Capture the address phase of every valid transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dph_valid <= 1'b0;
         r_dph_write <= 1'b0;
         r_dph_idx   <= '0;
      end else if (ahbls_hready) begin
         r_dph_valid <= ahbls_htrans[1];
         r_dph_write <= ahbls_hwrite;
         r_dph_idx   <= ahbls_haddr[3:2];
      end
   end

   assign w_wr      = r_dph_valid && r_dph_write && ahbls_hready;
   assign w_wr_csr  = w_wr && (r_dph_idx == reg_idx(OFF_CSR));
   assign w_wr_rate = w_wr && (r_dph_idx == reg_idx(OFF_RATE));
   assign w_wr_fifo = w_wr && (r_dph_idx == reg_idx(OFF_FIFO));
   assign w_wr_stat = w_wr && (r_dph_idx == reg_idx(OFF_STAT));
   assign w_flush   = w_wr_csr && ahbls_hwdata[CSR_FLUSH];

   // Scheduler: a pop is due on the PWM wrap that closes the sample period
   assign w_wrap      = r_en && (r_ctr == {W_PWM{1'b1}});
   assign w_sched_pop = w_wrap && (r_period == r_rate);
   // A flush in the same cycle discards the FIFO, so the due pop starves
   assign w_pop_ok        = w_sched_pop && !w_empty && !w_flush;
   assign w_underflow_set = w_sched_pop && !w_pop_ok;
   assign w_overflow_set  = w_wr_fifo && !w_flush && w_full && !w_pop_ok;

   apu_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_wr_fifo),
      .i_pop   (w_pop_ok),
      .i_flush (w_flush),
      .i_wdata (ahbls_hwdata),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Register writes; sticky flags set by events win over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en        <= 1'b0;
         r_irq_en    <= 1'b0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
         r_rate      <= '0;
         r_thresh    <= '0;
      end else begin
         if (w_wr_csr) begin
            r_en     <= ahbls_hwdata[CSR_EN];
            r_irq_en <= ahbls_hwdata[CSR_IRQ_EN];
         end
         if (w_wr_rate) begin
            r_rate <= ahbls_hwdata[7:0];
         end
         if (w_wr_stat) begin
            r_thresh <= ahbls_hwdata[STAT_THRESH_LSB +: 6];
         end
         r_underflow <= w_underflow_set |
                        (r_underflow & ~(w_wr_csr & ahbls_hwdata[CSR_UNDERFLOW]));
         r_overflow  <= w_overflow_set |
                        (r_overflow & ~(w_wr_csr & ahbls_hwdata[CSR_OVERFLOW]));
      end
   end

   // PWM counter and sample-period counter, both parked at 0 while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctr    <= '0;
         r_period <= '0;
      end else if (!r_en) begin
         r_ctr    <= '0;
         r_period <= '0;
      end else begin
         r_ctr <= r_ctr + 1'b1;
         if (w_wrap) begin
            // Equality compare: a RATE lowered below the running count lets
            // the counter run through 255 and wrap before matching
            r_period <= w_sched_pop ? 8'd0 : r_period + 8'd1;
         end
      end
   end

   // Current sample changes only on a wrap, so the duty derived from it
   // never moves mid-period; it returns to midscale when disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_current <= '0;
      end else if (!r_en) begin
         r_current <= '0;
      end else if (w_pop_ok) begin
         r_current <= w_fifo_rdata;
      end
   end

`ifdef APU_AUDIO_OUT_DITHER_EN
   localparam int          DITHER_BITS = 16 - W_PWM;
   localparam logic [15:0] DITHER_MASK = 16'((32'd1 << DITHER_BITS) - 32'd1);
   logic [15:0] r_lfsr;

   // Dither source advances once per PWM period so duty stays wrap-aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_wrap) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign w_dither = r_lfsr & DITHER_MASK;
`else
   assign w_dither = '0;
`endif

   // Signed sample -> unsigned offset, keep the top W_PWM bits
   assign w_samp_l = sat_add(r_current[15:0], w_dither);
   assign w_samp_r = sat_add(r_current[31:16], w_dither);
   assign w_off_l  = w_samp_l ^ 16'h8000;
   assign w_off_r  = w_samp_r ^ 16'h8000;
   assign w_duty_l = w_off_l[15 -: W_PWM];
   assign w_duty_r = w_off_r[15 -: W_PWM];

   // Registered PWM outputs and level interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_audio_l <= 1'b0;
         r_audio_r <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_audio_l <= r_en && (r_ctr < w_duty_l);
         r_audio_r <= r_en && (r_ctr < w_duty_r);
         r_irq     <= r_irq_en && (w_level <= r_thresh);
      end
   end

   // Read data from state during a read data phase, 0 otherwise
   always_comb begin
      ahbls_hrdata = '0;
      if (r_dph_valid && !r_dph_write) begin
         case (r_dph_idx)
            reg_idx(OFF_CSR): begin
               ahbls_hrdata[CSR_EN]        = r_en;
               ahbls_hrdata[CSR_IRQ_EN]    = r_irq_en;
               ahbls_hrdata[CSR_UNDERFLOW] = r_underflow;
               ahbls_hrdata[CSR_OVERFLOW]  = r_overflow;
            end
            reg_idx(OFF_RATE): begin
               ahbls_hrdata[7:0] = r_rate;
            end
            reg_idx(OFF_STAT): begin
               ahbls_hrdata[STAT_LEVEL_LSB +: 6]  = w_level;
               ahbls_hrdata[STAT_THRESH_LSB +: 6] = r_thresh;
            end
            default: ahbls_hrdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_apu_audio_out.sv
// Directed bench for apu_audio_out: register reset values, PWM duty,
// scheduler timing, FIFO overflow/full push+pop, IRQ and glitch-free update.
module tb_apu_audio_out;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ahbls_haddr;
   logic [1:0]  ahbls_htrans;
   logic        ahbls_hwrite;
   logic [2:0]  ahbls_hsize;
   logic        ahbls_hready;
   logic        ahbls_hready_resp;
   logic        ahbls_hresp;
   logic [31:0] ahbls_hwdata;
   logic [31:0] ahbls_hrdata;
   logic        irq;
   logic        audio_l;
   logic        audio_r;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   apu_audio_out #(
      .FIFO_DEPTH (8),
      .W_PWM      (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ahbls_haddr       (ahbls_haddr),
      .ahbls_htrans      (ahbls_htrans),
      .ahbls_hwrite      (ahbls_hwrite),
      .ahbls_hsize       (ahbls_hsize),
      .ahbls_hready      (ahbls_hready),
      .ahbls_hready_resp (ahbls_hready_resp),
      .ahbls_hresp       (ahbls_hresp),
      .ahbls_hwdata      (ahbls_hwdata),
      .ahbls_hrdata      (ahbls_hrdata),
      .irq               (irq),
      .audio_l           (audio_l),
      .audio_r           (audio_r)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge n settles, cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, cyc=%0d required completion", cyc);
      $fatal(1);
   end

   task automatic bus_idle();
      ahbls_haddr  = '0;
      ahbls_htrans = 2'b00;
      ahbls_hwrite = 1'b0;
      ahbls_hsize  = 3'b010;
      ahbls_hready = 1'b1;
      ahbls_hwdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus_idle();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Address phase now, commit at the second following posedge
   task automatic wr_body(input logic [15:0] a, input logic [31:0] d);
      ahbls_haddr  = a;
      ahbls_htrans = 2'b10;
      ahbls_hwrite = 1'b1;
      @(negedge clk);
      ahbls_htrans = 2'b00;
      ahbls_hwrite = 1'b0;
      ahbls_hwdata = d;
      @(posedge clk);
      #1;
      $display("write addr=%h data=%h cyc=%0d", a, d, cyc);
   endtask

   task automatic rd_body(input logic [15:0] a, output logic [31:0] d);
      ahbls_haddr  = a;
      ahbls_htrans = 2'b10;
      ahbls_hwrite = 1'b0;
      @(negedge clk);
      ahbls_htrans = 2'b00;
      d = ahbls_hrdata;
      $display("read  addr=%h data=%h cyc=%0d", a, d, cyc);
   endtask

   task automatic ahb_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_body(a, d);
   endtask

   task automatic ahb_read(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      rd_body(a, d);
   endtask

   // Write that commits exactly at posedge number t
   task automatic ahb_write_at(input logic [15:0] a, input logic [31:0] d, input int t);
      if (cyc > t - 2) begin
         n_cmp++; n_bad++;
         $display("FAIL sched_write: cyc=%0d already past required %0d", cyc, t - 2);
      end
      while (cyc < t - 2) @(negedge clk);
      wr_body(a, d);
   endtask

   // Read whose address is sampled at posedge t (data seen just after t)
   task automatic ahb_read_at(input logic [15:0] a, input int t, output logic [31:0] d);
      if (cyc > t - 1) begin
         n_cmp++; n_bad++;
         $display("FAIL sched_read: cyc=%0d already past required %0d", cyc, t - 1);
      end
      while (cyc < t - 1) @(negedge clk);
      rd_body(a, d);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      n_cmp++; if (audio_l !== 1'b0) begin n_bad++; $display("FAIL rst_audio_l: got %b want 0", audio_l); end
      n_cmp++; if (audio_r !== 1'b0) begin n_bad++; $display("FAIL rst_audio_r: got %b want 0", audio_r); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
      n_cmp++; if (ahbls_hrdata !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata: got %h want 0", ahbls_hrdata); end
      n_cmp++; if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b0) begin
         n_bad++; $display("FAIL rst_resp: got ready=%b resp=%b want 1/0", ahbls_hready_resp, ahbls_hresp);
      end
      for (int i = 0; i < 4; i++) begin
         ahb_read(16'(i * 4), d);
         n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_reg%0d: got %h want 0", i, d); end
      end
   endtask

   task automatic test_pwm_basic();
      logic [31:0] d;
      int e0, p, hl, hr;
      do_reset();
      ahb_write(16'h0004, 32'd0);
      ahb_write(16'h0008, 32'h7FFF8000);
      ahb_write(16'h0000, 32'h1);
      e0 = cyc;
      p  = e0 + 256;
      while (cyc < p) @(negedge clk);
      hl = 0; hr = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         hl += int'(audio_l);
         hr += int'(audio_r);
      end
      $display("pwm_basic highs l=%0d r=%0d", hl, hr);
      n_cmp++; if (hl != 0) begin n_bad++; $display("FAIL pwm_l_8000: got %0d high want 0", hl); end
      n_cmp++; if (hr != 255) begin n_bad++; $display("FAIL pwm_r_7fff: got %0d high want 255", hr); end
      ahb_read(16'h000C, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL pwm_level: got %h want 0", d); end
   endtask

   task automatic test_rate_sched();
      logic [31:0] d;
      logic [31:0] words [4];
      int duty_exp [5];
      int e0, p, hl;
      words    = '{32'h80008000, 32'h00000000, 32'hC000C000, 32'h40004000};
      duty_exp = '{0, 128, 64, 192, 192};
      do_reset();
      ahb_write(16'h0004, 32'd3);
      ahb_read(16'h0004, d);
      n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL rate_rb: got %h want 3", d); end
      for (int i = 0; i < 4; i++) ahb_write(16'h0008, words[i]);
      ahb_read(16'h000C, d);
      n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL rate_lvl0: got %h want 4", d); end
      ahb_write(16'h0000, 32'h1);
      e0 = cyc;
      for (int k = 1; k <= 5; k++) begin
         p = e0 + 1024 * k;
         if (k < 5) begin
            ahb_read_at(16'h000C, p - 1, d);
            n_cmp++; if (d !== 32'(5 - k)) begin n_bad++; $display("FAIL rate_pre%0d: got %h want %0d", k, d, 5 - k); end
            ahb_read_at(16'h000C, p, d);
            n_cmp++; if (d !== 32'(4 - k)) begin n_bad++; $display("FAIL rate_post%0d: got %h want %0d", k, d, 4 - k); end
         end else begin
            ahb_read_at(16'h0000, p - 1, d);
            n_cmp++; if (d !== 32'h001) begin n_bad++; $display("FAIL underflow_pre: got %h want 001", d); end
            ahb_read_at(16'h0000, p, d);
            n_cmp++; if (d !== 32'h101) begin n_bad++; $display("FAIL underflow_post: got %h want 101", d); end
         end
         hl = 0;
         for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hl += int'(audio_l);
         end
         $display("rate period %0d highs l=%0d", k, hl);
         n_cmp++; if (hl != duty_exp[k-1]) begin n_bad++; $display("FAIL rate_duty%0d: got %0d want %0d", k, hl, duty_exp[k-1]); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      int e0;
      do_reset();
      for (int i = 0; i < 9; i++) ahb_write(16'h0008, 32'h10000000 + 32'(i));
      ahb_read(16'h000C, d);
      n_cmp++; if (d !== 32'd8) begin n_bad++; $display("FAIL ovf_level: got %h want 8", d); end
      ahb_read(16'h0000, d);
      n_cmp++; if (d !== 32'h200) begin n_bad++; $display("FAIL ovf_flag: got %h want 200", d); end
      ahb_write(16'h0000, 32'h200);
      ahb_read(16'h0000, d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ovf_w1c: got %h want 0", d); end
      ahb_write(16'h0000, 32'h1);
      e0 = cyc;
      ahb_write_at(16'h0008, 32'hDEADBEEF, e0 + 256);
      ahb_read(16'h000C, d);
      n_cmp++; if (d !== 32'd8) begin n_bad++; $display("FAIL full_pushpop_level: got %h want 8", d); end
      ahb_read(16'h0000, d);
      n_cmp++; if (d !== 32'h001) begin n_bad++; $display("FAIL full_pushpop_csr: got %h want 001", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      int e0, p;
      do_reset();
      for (int i = 0; i < 3; i++) ahb_write(16'h0008, 32'h0);
      ahb_write(16'h000C, 32'h0200);
      ahb_write(16'h0000, 32'h5);
      e0 = cyc;
      repeat (2) @(negedge clk);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_lvl3: got %b want 0", irq); end
      p = e0 + 256;
      while (cyc < p) @(negedge clk);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_lag: got %b want 0", irq); end
      @(negedge clk);
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise: got %b want 1", irq); end
      ahb_write(16'h0008, 32'h0);
      @(negedge clk);
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_fall_lag: got %b want 1", irq); end
      @(negedge clk);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall: got %b want 0", irq); end
      ahb_write(16'h0000, 32'h7);
      ahb_read(16'h000C, d);
      n_cmp++; if (d !== 32'h0200) begin n_bad++; $display("FAIL flush_stat: got %h want 0200", d); end
      ahb_read(16'h0000, d);
      n_cmp++; if (d !== 32'h005) begin n_bad++; $display("FAIL flush_csr: got %h want 005", d); end
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL flush_irq: got %b want 1", irq); end
   endtask

   task automatic test_no_runt();
      int e0, p1, p2, hl, hr, rl, rr;
      logic pl, pr;
      do_reset();
      ahb_write(16'h0004, 32'd0);
      ahb_write(16'h0008, 32'h80008000);
      ahb_write(16'h0000, 32'h1);
      e0 = cyc;
      p1 = e0 + 256;
      p2 = e0 + 512;
      ahb_write_at(16'h0008, 32'h00000000, p1 + 100);
      hl = 0; hr = 0;
      do begin
         @(negedge clk);
         hl += int'(audio_l);
         hr += int'(audio_r);
      end while (cyc < p2);
      n_cmp++; if (hl != 0 || hr != 0) begin n_bad++; $display("FAIL runt: got highs l=%0d r=%0d want 0/0", hl, hr); end
      pl = audio_l; pr = audio_r;
      hl = 0; hr = 0; rl = 0; rr = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         hl += int'(audio_l);
         hr += int'(audio_r);
         if (audio_l && !pl) rl++;
         if (audio_r && !pr) rr++;
         pl = audio_l; pr = audio_r;
      end
      $display("no_runt highs l=%0d r=%0d rises l=%0d r=%0d", hl, hr, rl, rr);
      n_cmp++; if (hl != 128 || hr != 128) begin n_bad++; $display("FAIL mid_duty: got l=%0d r=%0d want 128/128", hl, hr); end
      n_cmp++; if (rl != 1 || rr != 1) begin n_bad++; $display("FAIL mid_pulses: got l=%0d r=%0d want 1/1", rl, rr); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_idle();
      test_reset();
      test_pwm_basic();
      test_rate_sched();
      test_overflow();
      test_irq();
      test_no_runt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
